// File: rtl/dbus_uncached_unit.sv
// Uncached data-bus unit: turns one accepted upstream request into a single-beat
// downstream transaction, with a cycle-count timeout that returns ERR_DATA.
module dbus_uncached_unit #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        req_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_is_write,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_strobe,
  output logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        mem_last,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Counter holds cycles already spent in REQ, so it only needs to reach TIMEOUT-1.
  localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign req_addr_ok = (state == IDLE) && req_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_valid    <= 1'b0;
      mem_is_write <= 1'b0;
      mem_size     <= '0;
      mem_addr     <= '0;
      mem_strobe   <= '0;
      mem_data     <= '0;
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_data_ok <= 1'b0;
          resp_err     <= 1'b0;
          if (req_valid) begin
            mem_addr     <= req_addr;
            mem_size     <= req_size;
            mem_strobe   <= req_strobe;
            mem_data     <= req_data;
            mem_is_write <= (req_strobe != 4'b0000);
            mem_valid    <= 1'b1;
            cnt          <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          // A completing beat wins over a timeout expiring in the same cycle.
          if (mem_ready && mem_last) begin
            resp_data    <= mem_rdata;
            resp_err     <= 1'b0;
            mem_valid    <= 1'b0;
            resp_data_ok <= 1'b1;
            state        <= DONE;
          end else if (cnt == LAST_CNT) begin
            resp_data    <= ERR_DATA;
            resp_err     <= 1'b1;
            mem_valid    <= 1'b0;
            resp_data_ok <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          resp_data_ok <= 1'b0;
          resp_err     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dbus_uncached_unit.md
DBUS_UNCACHED_UNIT -- requirements
Module: dbus_uncached_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles waited for mem_ready before the bus-error path is taken.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset, sampled at the rising edge of clk.
REQ-005 SHALL have port req_valid, input, 1: the upstream translated data request, taken when d_uncached is high, is present.
REQ-006 SHALL have port req_addr, input, 32: physical address.
REQ-007 SHALL have port req_size, input, 3: access size (0=byte, 1=half, 2=word).
REQ-008 SHALL have port req_strobe, input, 4: byte write enables; 0 means read.
REQ-009 SHALL have port req_data, input, 32: write data.
REQ-010 SHALL have port req_addr_ok, output, 1: request accepted this cycle.
REQ-011 SHALL have port resp_data_ok, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_data, output, 32: read data, valid while resp_data_ok is high.
REQ-013 SHALL have port resp_err, output, 1: timeout flag, valid while resp_data_ok is high.
REQ-014 SHALL have ports mem_valid (output, 1), mem_is_write (output, 1), mem_size (output, 3), mem_addr (output, 32), mem_strobe (output, 4) and mem_data (output, 32): the downstream single-beat bus request.
REQ-015 SHALL have ports mem_ready (input, 1), mem_last (input, 1) and mem_rdata (input, 32): the downstream bus response.

Function
REQ-016 SHALL implement the FSM states IDLE, REQ, DONE.
REQ-017 SHALL drive req_addr_ok = req_valid combinationally in IDLE, and 0 in every other state.
REQ-018 SHALL, on IDLE && req_valid, register addr, size, strobe and data, set is_write = (strobe != 0) and go to REQ.
REQ-019 SHALL hold mem_valid = 1 in REQ, with all mem_* fields driven from registers and stable until completion.
REQ-020 SHALL complete in REQ on mem_ready && mem_last: capture mem_rdata (captured on writes too, value don't-care), clear the error flag and go to DONE.
REQ-021 SHALL ignore mem_ready with mem_last = 0 (that beat is not captured) and stay in REQ.
REQ-022 SHALL count cycles spent in REQ with a counter zeroed on entry, and when the count reaches TIMEOUT without completion: deassert mem_valid, load ERR_DATA, set the error flag and go to DONE.
REQ-023 SHALL pulse resp_data_ok for exactly one cycle in DONE, with resp_data and resp_err held from their registers, then return to IDLE.
REQ-024 SHALL keep resp_data_ok = 0 and resp_err = 0 outside DONE.
REQ-025 SHALL have a best-case latency of: accept at cycle N, mem_valid at N+1, mem_ready&&last at N+1, resp_data_ok at N+2.
REQ-026 SHALL not accept a new request in DONE; a back-to-back request is accepted at the earliest in the IDLE cycle following DONE.
REQ-027 SHALL have at most one transaction outstanding.
REQ-028 SHALL pass req_data and req_strobe through unmodified; the unit performs no lane shifting.

Reset
REQ-029 SHALL, while reset is high, force state = IDLE, counter = 0, all data/error registers = 0, and mem_valid, resp_data_ok, resp_err = 0.
REQ-030 SHALL have req_addr_ok = 0 while reset is high, regardless of req_valid.
REQ-031 SHALL, on reset asserted in REQ, abandon the transaction (mem_valid = 0 from the next cycle) and produce no resp_data_ok pulse.
REQ-032 SHALL ignore any later mem_ready that belongs to the abandoned transaction.

Verification
REQ-033 SHALL be covered by a read test: req addr 0x1FD0_0000, strobe 0, size 2; mem_ready&&last with rdata 0x1234_5678 one cycle after mem_valid -> resp_data_ok at N+2, resp_data 0x1234_5678, resp_err 0.
REQ-034 SHALL be covered by a write test: addr 0x1FAF_F000, strobe 4'b0011, data 0xAAAA_5555 -> mem_is_write 1, mem_strobe 0011, mem_data 0xAAAA_5555 stable for the 3 stall cycles before ready; single resp_data_ok pulse.
REQ-035 SHALL be covered by a timeout test with TIMEOUT = 4 and mem_ready never asserted -> mem_valid high for exactly 4 cycles, then resp_data_ok=1, resp_err=1, resp_data 0xDEAD_BEEF.
REQ-036 SHALL be covered by a back-to-back test with req_valid held high across two requests -> req_addr_ok high only in IDLE cycles; exactly 2 resp_data_ok pulses, in order.
REQ-037 SHALL be covered by a mid-transaction reset test: reset pulsed in REQ, then mem_ready asserted -> no resp_data_ok; next request completes normally.
REQ-038 SHALL be covered by a non-last beat test: mem_ready=1 with mem_last=0 for 2 cycles, then last -> unit stays in REQ and returns only the final beat's rdata.
